// File: rtl/upsample2x2_bin_stream_if.sv
// Single-bit pixel stream with a valid/ready handshake and an end-of-frame marker.
// The slave view omits the marker because the upsampler derives frame boundaries itself.
interface upsample2x2_bin_stream_if;
    logic valid;
    logic ready;
    logic pixel;
    logic last;

    modport master (output valid, output pixel, output last, input ready);
    modport slave  (input valid, input pixel, output ready);
endinterface

// File: rtl/upsample2x2_bin_stream.sv
// Binary 2x2 nearest-neighbour upsampler: buffers one input row, then replays it
// twice with every pixel doubled, so each input pixel becomes a 2x2 output block.
module upsample2x2_bin_stream #(
    parameter int IN_WIDTH  = 13,
    parameter int IN_HEIGHT = 13
) (
    input  logic                            clk,
    input  logic                            reset,
    upsample2x2_bin_stream_if.slave         in_stream_i,
    upsample2x2_bin_stream_if.master        out_stream_o
);
    // state | meaning
    // FILL  | accepting one input row into the line buffer
    // EMIT  | replaying the buffered row twice, each pixel sent twice

    localparam int COL_W  = (IN_WIDTH  > 1) ? $clog2(IN_WIDTH)  : 1;
    localparam int ROW_W  = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
    localparam int OCOL_W = $clog2(2 * IN_WIDTH);

    localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(IN_WIDTH - 1);
    localparam logic [ROW_W-1:0]  ROW_MAX  = ROW_W'(IN_HEIGHT - 1);
    localparam logic [OCOL_W-1:0] OCOL_MAX = OCOL_W'(2 * IN_WIDTH - 1);

    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t              state_q,   state_d;
    logic [COL_W-1:0]    in_col_q,  in_col_d;
    logic [ROW_W-1:0]    in_row_q,  in_row_d;
    logic [OCOL_W-1:0]   out_col_q, out_col_d;
    logic                rep_q,     rep_d;
    logic [IN_WIDTH-1:0] linebuf_q;
    logic                lb_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FILL;
            in_col_q  <= '0;
            in_row_q  <= '0;
            out_col_q <= '0;
            rep_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_col_q  <= in_col_d;
            in_row_q  <= in_row_d;
            out_col_q <= out_col_d;
            rep_q     <= rep_d;
        end
    end

    // Line buffer needs no reset: every row is fully rewritten before it is read.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf_q[in_col_q] <= in_stream_i.pixel;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_col_d  = in_col_q;
        in_row_d  = in_row_q;
        out_col_d = out_col_q;
        rep_d     = rep_q;
        lb_we     = 1'b0;

        case (state_q)
            FILL: begin
                if (in_stream_i.valid) begin
                    lb_we = 1'b1;
                    if (in_col_q == COL_MAX) begin
                        in_col_d  = '0;
                        out_col_d = '0;
                        rep_d     = 1'b0;
                        state_d   = EMIT;
                    end else begin
                        in_col_d = in_col_q + COL_W'(1);
                    end
                end
            end
            EMIT: begin
                if (out_stream_o.ready) begin
                    if (out_col_q == OCOL_MAX) begin
                        out_col_d = '0;
                        if (!rep_q) begin
                            rep_d = 1'b1;
                        end else begin
                            rep_d    = 1'b0;
                            in_row_d = (in_row_q == ROW_MAX) ? '0 : in_row_q + ROW_W'(1);
                            state_d  = FILL;
                        end
                    end else begin
                        out_col_d = out_col_q + OCOL_W'(1);
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    // All outputs decode registered state only; no input-to-output combinational path.
    assign in_stream_i.ready  = (state_q == FILL);
    assign out_stream_o.valid = (state_q == EMIT);
    assign out_stream_o.pixel = (state_q == EMIT) & linebuf_q[out_col_q[OCOL_W-1:1]];
    assign out_stream_o.last  = (state_q == EMIT) && rep_q && (out_col_q == OCOL_MAX)
                                && (in_row_q == ROW_MAX);
endmodule

// File: tb/tb_upsample2x2_bin_stream.sv
// Bench for the 2x2 binary upsampler: a 4x2 instance and a default 13x13 instance
// share one clock and reset; a mux selects which one the stimulus loop talks to.
module tb_upsample2x2_bin_stream;
    localparam int WA = 4;
    localparam int HA = 2;
    localparam int WB = 13;
    localparam int HB = 13;
    localparam int CYC_LIMIT = 20000;

    typedef logic [63:0] val_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic drv_valid = 1'b0;
    logic drv_pixel = 1'b0;
    logic drv_ready = 1'b0;
    logic sel       = 1'b0;

    upsample2x2_bin_stream_if in_a ();
    upsample2x2_bin_stream_if out_a ();
    upsample2x2_bin_stream_if in_b ();
    upsample2x2_bin_stream_if out_b ();

    assign in_a.valid  = drv_valid & ~sel;
    assign in_a.pixel  = drv_pixel;
    assign in_a.last   = 1'b0;
    assign out_a.ready = drv_ready & ~sel;
    assign in_b.valid  = drv_valid & sel;
    assign in_b.pixel  = drv_pixel;
    assign in_b.last   = 1'b0;
    assign out_b.ready = drv_ready & sel;

    logic mon_ready, mon_valid, mon_pixel, mon_last;
    assign mon_ready = sel ? in_b.ready  : in_a.ready;
    assign mon_valid = sel ? out_b.valid : out_a.valid;
    assign mon_pixel = sel ? out_b.pixel : out_a.pixel;
    assign mon_last  = sel ? out_b.last  : out_a.last;

    upsample2x2_bin_stream #(.IN_WIDTH(WA), .IN_HEIGHT(HA)) dut_a (
        .clk(clk), .reset(reset), .in_stream_i(in_a), .out_stream_o(out_a));
    upsample2x2_bin_stream #(.IN_WIDTH(WB), .IN_HEIGHT(HB)) dut_b (
        .clk(clk), .reset(reset), .in_stream_i(in_b), .out_stream_o(out_b));

    int n_pass  = 0;
    int n_total = 0;

    logic in_q[$];
    logic out_q[$];
    logic last_q[$];
    int   stall_bad;
    int   emit_bad;

    typedef struct {
        logic [3:0]  r0;
        logic [3:0]  r1;
        logic [31:0] exp_stream;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input val_t act, input val_t exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic load_rows(input logic [3:0] r0, input logic [3:0] r1);
        in_q.delete();
        for (int k = 0; k < 4; k++) in_q.push_back(r0[3-k]);
        for (int k = 0; k < 4; k++) in_q.push_back(r1[3-k]);
    endtask

    task automatic load_random(input int n);
        in_q.delete();
        for (int k = 0; k < n; k++) in_q.push_back(1'($urandom_range(1)));
    endtask

    // rdy_mode: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random
    task automatic run_stream(input int stall_pct, input int rdy_mode,
                              input int stop_out, output int cycles);
        int   in_idx = 0;
        int   n_out  = 0;
        int   cyc    = 0;
        int   pat[4];
        logic stalled = 1'b0;
        logic prev_pix = 1'b0;
        logic prev_last = 1'b0;
        pat = '{1, 0, 0, 1};
        out_q.delete();
        last_q.delete();
        stall_bad = 0;
        emit_bad  = 0;
        cycles    = -1;
        while (n_out < stop_out && cyc < CYC_LIMIT) begin
            @(negedge clk);
            if (stalled && (mon_pixel !== prev_pix || mon_last !== prev_last)) stall_bad++;
            if (in_idx >= in_q.size())  drv_valid = 1'b0;
            else if (!mon_ready)        drv_valid = 1'b1;
            else                        drv_valid = ($urandom_range(99) >= stall_pct);
            drv_pixel = drv_valid ? in_q[in_idx] : 1'($urandom_range(1));
            case (rdy_mode)
                0:       drv_ready = 1'b1;
                1:       drv_ready = 1'(pat[cyc % 4]);
                default: drv_ready = 1'($urandom_range(1));
            endcase
            cyc++;
            if (mon_valid && mon_ready) emit_bad++;
            if (mon_ready && drv_valid) in_idx++;
            if (mon_valid && drv_ready) begin
                out_q.push_back(mon_pixel);
                last_q.push_back(mon_last);
                n_out++;
                if (n_out == stop_out) cycles = cyc;
            end
            stalled   = mon_valid && !drv_ready;
            prev_pix  = mon_pixel;
            prev_last = mon_last;
        end
        check("outputs_before_timeout", 64'(n_out), 64'(stop_out));
    endtask

    task automatic idle();
        @(negedge clk);
        drv_valid = 1'b0;
        drv_ready = 1'b0;
    endtask

    task automatic pack32(output logic [31:0] acc, output logic [31:0] lmask);
        acc = '0;
        lmask = '0;
        for (int k = 0; k < out_q.size() && k < 32; k++) begin
            acc   = {acc[30:0], out_q[k]};
            lmask = {lmask[30:0], last_q[k]};
        end
    endtask

    // Reference: output (r,c) of frame f is input (r/2, c/2); max-pool must undo it.
    task automatic compare_model(input int w, input int h, input int nframes, input string tag);
        int fsz = 4 * w * h;
        int pix_bad = 0;
        int last_bad = 0;
        int pool_bad = 0;
        int n_last = 0;
        check({tag, "_out_count"}, 64'(out_q.size()), 64'(nframes * fsz));
        for (int k = 0; k < out_q.size(); k++) begin
            int f   = k / fsz;
            int rem = k % fsz;
            int r   = rem / (2 * w);
            int c   = rem % (2 * w);
            int src = f * w * h + (r / 2) * w + c / 2;
            if (src >= in_q.size() || out_q[k] !== in_q[src]) pix_bad++;
            if (last_q[k] !== (rem == fsz - 1)) last_bad++;
            if (last_q[k] === 1'b1) n_last++;
        end
        if (out_q.size() != nframes * fsz) pool_bad = 1;
        else begin
            for (int f = 0; f < nframes; f++)
                for (int r = 0; r < h; r++)
                    for (int c = 0; c < w; c++) begin
                        int   base = f * fsz + (2 * r) * (2 * w) + 2 * c;
                        logic o = out_q[base] | out_q[base+1] |
                                  out_q[base+2*w] | out_q[base+2*w+1];
                        if (o !== in_q[f * w * h + r * w + c]) pool_bad++;
                    end
        end
        check({tag, "_pixel_mismatches"}, 64'(pix_bad), 64'(0));
        check({tag, "_last_mismatches"},  64'(last_bad), 64'(0));
        check({tag, "_last_count"},       64'(n_last), 64'(nframes));
        check({tag, "_pool_roundtrip_errors"}, 64'(pool_bad), 64'(0));
    endtask

    initial begin
        int          cyc;
        logic [31:0] acc;
        logic [31:0] lmask;

        vecs[0] = '{4'b1010, 4'b0110, 32'hCCCC3C3C};
        vecs[1] = '{4'b1111, 4'b0000, 32'hFFFF0000};
        vecs[2] = '{4'b0001, 4'b1000, 32'h0303C0C0};
        vecs[3] = '{4'b0101, 4'b1001, 32'h3333C3C3};
        vecs[4] = '{4'b0011, 4'b1100, 32'h0F0FF0F0};

        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        sel = 1'b0;
        #1 check("reset_outputs_a", 64'({mon_ready, mon_valid, mon_pixel, mon_last}), 64'(4'b1000));
        sel = 1'b1;
        #1 check("reset_outputs_b", 64'({mon_ready, mon_valid, mon_pixel, mon_last}), 64'(4'b1000));
        sel = 1'b0;

        for (int i = 0; i < 5; i++) begin
            load_rows(vecs[i].r0, vecs[i].r1);
            run_stream(0, 0, 32, cyc);
            pack32(acc, lmask);
            check($sformatf("vec%0d_stream", i), 64'(acc), 64'(vecs[i].exp_stream));
            check($sformatf("vec%0d_last_pos", i), 64'(lmask), 64'(32'h1));
            check($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(40));
        end

        load_rows(4'b1010, 4'b0110);
        run_stream(0, 1, 32, cyc);
        pack32(acc, lmask);
        check("bp_stream", 64'(acc), 64'(32'hCCCC3C3C));
        check("bp_last_pos", 64'(lmask), 64'(32'h1));
        check("bp_hold_violations", 64'(stall_bad), 64'(0));

        load_random(4 * WA * HA);
        run_stream(40, 2, 4 * 4 * WA * HA, cyc);
        compare_model(WA, HA, 4, "gaps");
        check("gaps_ready_in_emit", 64'(emit_bad), 64'(0));
        check("gaps_hold_violations", 64'(stall_bad), 64'(0));

        idle();
        sel = 1'b1;
        load_random(3 * WB * HB);
        run_stream(0, 0, 3 * 4 * WB * HB, cyc);
        check("b2b_cycles", 64'(cyc), 64'(3 * 5 * WB * HB));
        compare_model(WB, HB, 3, "b2b");
        check("b2b_ready_in_emit", 64'(emit_bad), 64'(0));
        idle();
        sel = 1'b0;

        load_rows(4'b1010, 4'b0110);
        run_stream(0, 0, 26, cyc);
        @(negedge clk);
        drv_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_outputs", 64'({mon_ready, mon_valid, mon_pixel, mon_last}), 64'(4'b1000));
        load_rows(4'b1111, 4'b1111);
        run_stream(0, 0, 32, cyc);
        pack32(acc, lmask);
        check("midrst_stream", 64'(acc), 64'(32'hFFFFFFFF));
        check("midrst_last_pos", 64'(lmask), 64'(32'h1));
        check("midrst_cycles", 64'(cyc), 64'(40));

        idle();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/upsample2x2_bin_stream.md
# upsample2x2_bin_stream

Binary 2x2 nearest-neighbour upsampler for 1-bit feature-map streams. Each input pixel is replicated into a 2x2 output block, so an IN_WIDTH x IN_HEIGHT raster becomes a 2*IN_WIDTH x 2*IN_HEIGHT raster. It performs the inverse spatial operation of the binary 2x2 max-pool stage and feeds decoder-side or unpooling layers of the BCNN datapath. Both ports use valid/ready handshakes.

## Interface
- IN_WIDTH, 13, input row length in pixels (>=2)
- IN_HEIGHT, 13, input rows per frame (>=1)
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  in_pixel valid
- in_ready  out  1  block accepts in_pixel this cycle
- in_pixel  in  1  binary input pixel, raster order
- out_valid  out  1  out_pixel valid
- out_ready  in  1  downstream accepts out_pixel this cycle
- out_pixel  out  1  binary output pixel, raster order
- out_last  out  1  high with the final output pixel of a frame

## Operation
- Storage: one line buffer, IN_WIDTH x 1 bit.
- Counters:
  - in_col: 0..IN_WIDTH-1
  - in_row: 0..IN_HEIGHT-1
  - out_col: 0..2*IN_WIDTH-1
  - rep: 0..1, selects the first or second output row copy
  - Each counter is sized with $clog2 of its range, minimum 1 bit.
- Transfers: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- FSM states: FILL, EMIT.
  - **FILL**
    - in_ready=1, out_valid=0.
    - On each input transfer, linebuf[in_col] <= in_pixel and in_col increments.
    - On the transfer where in_col==IN_WIDTH-1: in_col <= 0, out_col <= 0, rep <= 0, go to EMIT.
  - **EMIT**
    - in_ready=0, out_valid=1, out_pixel = linebuf[out_col>>1].
    - On each output transfer, out_col increments.
    - At out_col==2*IN_WIDTH-1 with rep==0: out_col <= 0, rep <= 1.
    - At out_col==2*IN_WIDTH-1 with rep==1:
      - If in_row==IN_HEIGHT-1, in_row <= 0; otherwise in_row <= in_row+1.
      - Go to FILL.
- out_last = EMIT && rep==1 && out_col==2*IN_WIDTH-1 && in_row==IN_HEIGHT-1.
- Frame wrap: after the last pixel of a frame, the block expects row 0 of the next frame. There is no idle gap and no other state.
- in_pixel is ignored whenever in_ready=0. No input data is lost, because the upstream must hold its data until the handshake completes.

## Timing
- Reset values:
  - Outputs: in_ready=1, out_valid=0, out_pixel=0, out_last=0.
  - State: FILL; all counters 0.
  - Line buffer contents are don't-care, since every row is fully rewritten before it is read.
- Output registering: out_valid, out_pixel, out_last and in_ready are functions of registered state only. There is no combinational path from in_valid or out_ready to any output.
- Latency: the first output pixel of an output row is valid in the cycle after the last input pixel of the corresponding input row is accepted.
- Throughput with out_ready held at 1 and no input stalls:
  - IN_WIDTH fill cycles plus 4*IN_WIDTH emit cycles per input row.
  - Total per frame: 5*IN_WIDTH*IN_HEIGHT cycles.
- Backpressure: while out_valid=1 and out_ready=0, out_pixel, out_last and all counters hold.
- Input stalls: while in_valid=0 in FILL, in_col holds and no output is produced.
- Reset mid-operation: in the cycle after reset is asserted, all outputs return to their reset values. Any partial row or frame is discarded, and the next accepted pixel is treated as row 0, column 0.

## Test plan
- **Basic 4x2 frame.** IN_WIDTH=4, IN_HEIGHT=2, out_ready=1. Input rows 1010 and 0110 produce output rows 11001100, 11001100, 00111100, 00111100. out_last is high only on the 32nd output pixel; the frame takes 40 cycles.
- **Backpressure.** Same frame, with out_ready toggling 1,0,0,1 repeating. The output sequence is identical to the basic case, and out_pixel and out_last never change while out_ready=0.
- **Input gaps and handshake.** in_valid is randomly deasserted in FILL, and in_valid is held at 1 during EMIT. The line buffer captures only handshaked pixels, in_ready=0 throughout EMIT, and the output still matches the golden 2x model.
- **Back-to-back frames.** Three default 13x13 frames are streamed with random data. The output equals pixel-wise replication of each frame (26x26 each), out_last fires exactly 3 times, and no idle cycle occurs between frames.
- **Reset mid-row.** reset is asserted for 1 cycle after 2 output pixels of row 1, copy 1. The next cycle shows out_valid=0, in_ready=1, out_last=0. The following frame of 4x2 all-ones yields 32 ones with out_last on the 32nd pixel.
- **Pool round-trip check.** The upsampler output is fed into the 2x2 binary max-pool stage. The pooled output reproduces the original input frame exactly.
